// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   Chunked ripple-carry adder/subtractor split over STAGES pipeline stages.
//   A beat is captured into rank 0 (operands, b already inverted for subtract,
//   carry-in already resolved). Stage k (1..STAGES) adds one CHUNK of the
//   operands with the carry registered by the previous rank, so a result is
//   presented exactly STAGES cycles after acceptance. The whole pipeline
//   advances together whenever in_ready is high (global stall).
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset, clears every register
//   in_valid   : operand beat present
//   in_ready   : beat accepted this cycle when in_valid is also high
//   a, b       : operands, WIDTH bits
//   cin        : carry-in for add mode (ignored when sub=1)
//   sub        : 0 = a + b + cin, 1 = a - b
//   out_valid  : result beat present
//   out_ready  : downstream consumes the result
//   sum, cout  : result; in subtract mode cout=1 means no borrow (a >= b)
// -----------------------------------------------------------------------------
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CHUNK = WIDTH / STAGES;

   // Rank 0 is the capture register; rank k (k>=1) holds the state after
   // chunk k-1 has been summed. Rank STAGES drives the outputs.
   logic [STAGES:0]            valid_q, valid_d;
   logic [STAGES:0]            carry_q, carry_d;
   // acc rotates right by CHUNK per stage: the not-yet-summed a chunks sit at
   // the bottom, finished sum chunks enter at the top. After STAGES rotations
   // it holds the complete sum in natural bit order.
   logic [STAGES:0][WIDTH-1:0] acc_q, acc_d;

   logic                        advance_s;
   logic [STAGES-1:0][CHUNK-1:0] bchunk_s;
   logic [STAGES:1][CHUNK:0]    part_s;

   assign in_ready  = ~valid_q[STAGES] | out_ready;
   assign advance_s = in_ready;

   assign out_valid = valid_q[STAGES];
   assign sum       = acc_q[STAGES];
   assign cout      = carry_q[STAGES];

   // The b operand only needs its remaining (unsummed) chunks, so each rank
   // keeps a progressively narrower copy; the low chunk is the one consumed
   // by the next stage.
   for (genvar k = 0; k < STAGES; k++) begin : g_b
      localparam int BW = WIDTH - k * CHUNK;
      logic [BW-1:0] b_q, b_d;

      if (k == 0) begin : g_first
         // Capture b, inverting it here so sub need not be held afterwards.
         always_comb begin
            if (advance_s) begin
               b_d = sub ? ~b : b;
            end else begin
               b_d = b_q;
            end
         end
      end else begin : g_next
         // Drop the chunk the previous stage consumed and pass the rest on.
         always_comb begin
            if (advance_s) begin
               b_d = g_b[k-1].b_q[WIDTH-(k-1)*CHUNK-1:CHUNK];
            end else begin
               b_d = b_q;
            end
         end
      end

      // b operand rank register.
      always_ff @(posedge clk) begin
         if (rst) begin
            b_q <= '0;
         end else begin
            b_q <= b_d;
         end
      end

      assign bchunk_s[k] = b_q[CHUNK-1:0];
   end

   // Next-state for valid, carry and accumulator ranks; all hold on a stall.
   always_comb begin
      part_s = '0;
      if (advance_s) begin
         valid_d[0] = in_valid;
         acc_d[0]   = a;
         carry_d[0] = sub ? 1'b1 : cin;
         for (int k = 1; k <= STAGES; k++) begin
            part_s[k]  = {1'b0, acc_q[k-1][CHUNK-1:0]}
                       + {1'b0, bchunk_s[k-1]}
                       + {{CHUNK{1'b0}}, carry_q[k-1]};
            valid_d[k] = valid_q[k-1];
            carry_d[k] = part_s[k][CHUNK];
            acc_d[k]   = (acc_q[k-1] >> CHUNK)
                       | (WIDTH'(part_s[k][CHUNK-1:0]) << (WIDTH - CHUNK));
         end
      end else begin
         valid_d = valid_q;
         carry_d = carry_q;
         acc_d   = acc_q;
      end
   end

   // Pipeline registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         acc_q   <= '0;
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4). A negedge
//   monitor keeps a queue of expected results computed with plain arithmetic
//   and checks every presented result; directed tables and sequences check
//   latency, backpressure, reset flush and bubbles via a per-cycle history.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int W   = 16;
   localparam int LAT = 4;
   localparam int HN  = 8192;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [W:0] exp_q[$];
   logic       hist_ov[HN];
   logic [W:0] hist_res[HN];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t tbl[8];

   pipelined_adder #(.WIDTH(W), .STAGES(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: add is plain (W+1)-bit addition; subtract is a-b with
   // cout meaning "no borrow".
   function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
      if (s) return {(x >= y) ? 1'b1 : 1'b0, x - y};
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (cyc < HN) begin
         hist_ov[cyc]  = out_valid;
         hist_res[cyc] = {cout, sum};
      end
      if (rst) begin
         exp_q.delete();
      end else begin
         check("in_ready_rule", {31'd0, in_ready}, {31'd0, ~out_valid | out_ready});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", {15'd0, cout, sum}, 32'hFFFF_FFFF);
            end else begin
               check("result", {15'd0, cout, sum}, {15'd0, exp_q[0]});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, cin, sub));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand(input logic v);
      in_valid = v;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      sub      = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      int cs[8];
      logic ivs[8];

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
      tbl[2] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
      tbl[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
      tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[7] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_sum_cout", {15'd0, cout, sum}, 32'd0);
      tick();

      // Directed table: isolated beats, exact latency and value.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
         tick();
         c0 = cyc;
         in_valid = 1'b0; sub = ~tbl[i].sub;  // sub need not be held
         repeat (LAT + 2) tick();
         check("tbl_early", {31'd0, hist_ov[c0+LAT-1]}, 32'd0);
         check("tbl_valid", {31'd0, hist_ov[c0+LAT]}, 32'd1);
         check("tbl_value", {15'd0, hist_res[c0+LAT]}, {15'd0, tbl[i].exp_cout, tbl[i].exp_sum});
      end

      // Streaming: 8 back-to-back beats.
      for (int i = 0; i < 8; i++) begin
         drive_rand(1'b1);
         tick();
         if (i == 0) c0 = cyc;
      end
      in_valid = 1'b0;
      repeat (LAT + 4) tick();
      check("stream_early", {31'd0, hist_ov[c0+LAT-1]}, 32'd0);
      for (int i = 0; i < 8; i++) check("stream_valid", {31'd0, hist_ov[c0+LAT+i]}, 32'd1);
      check("stream_end", {31'd0, hist_ov[c0+LAT+8]}, 32'd0);

      // Backpressure: fill with out_ready low, hold 3 cycles, then drain.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_rand(1'b1);
         tick();
      end
      drive_rand(1'b1);  // sixth beat must wait for the stall to clear
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_queue_depth", exp_q.size(), 32'd5);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      check("bp_drained", exp_q.size(), 32'd0);

      // Reset mid-flight, with a beat offered during the reset cycle.
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         tick();
      end
      rst = 1'b1;
      drive_rand(1'b1);
      tick();
      c0 = cyc;
      rst = 1'b0; in_valid = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 9; i++) check("rst_flush", {31'd0, hist_ov[c0+i]}, 32'd0);

      // Bubbles: alternate in_valid.
      for (int i = 0; i < 8; i++) begin
         drive_rand((i % 2) == 0);
         ivs[i] = in_valid;
         tick();
         cs[i] = cyc;
      end
      in_valid = 1'b0;
      repeat (LAT + 2) tick();
      for (int i = 0; i < 8; i++) check("bubble", {31'd0, hist_ov[cs[i]+LAT]}, {31'd0, ivs[i]});

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         drive_rand(1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (12) tick();
      check("final_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
